// File: rtl/sram_stream_adapter_pkg.sv
// sram_stream_adapter_pkg: width helpers shared by the adapter and its response fifo
package sram_stream_adapter_pkg;
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned div_ceil(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: registered-output response fifo, wraps modulo Depth, push+pop allowed when full
module sram_rsp_fifo
  import sram_stream_adapter_pkg::*;
#(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 32,
  parameter int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);
  localparam int unsigned PtrW = addr_width(Depth);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] count_q;
  logic do_push, do_pop;
  always_comb begin
    full_o = count_q == CntW'(Depth);
    empty_o = count_q == '0;
    count_o = count_q;
    data_o = mem_q[rd_q];
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_pop) rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
      if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !pop_i));
endmodule

// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter: valid/ready request stream to 1-cycle tc_sram port with credit-guarded read responses
module sram_stream_adapter
  import sram_stream_adapter_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned RspDepth  = 3,
  parameter int unsigned AddrWidth = addr_width(NumWords),
  parameter int unsigned BeWidth   = div_ceil(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);
  localparam int unsigned CntW = $clog2(RspDepth + 1);
  logic init_q, inflight_q, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0] credit_sum;
  always_comb begin
    credit_sum = {1'b0, fifo_count} + (CntW + 1)'(inflight_q);
    req_ready_o = init_q && (credit_sum < (CntW + 1)'(RspDepth));
    sram_req_o = req_valid_i && req_ready_o;
    sram_we_o = req_we_i;
    sram_addr_o = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o = req_be_i;
    rsp_valid_o = !fifo_empty;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      inflight_q <= sram_req_o && !req_we_i;
    end
  end
  sram_rsp_fifo #(.Depth(RspDepth), .Width(DataWidth)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (inflight_q),
    .data_i (sram_rdata_i),
    .pop_i  (rsp_ready_i),
    .data_o (rsp_rdata_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );
  full_blocks: assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_full |-> !req_ready_o);
  req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_valid_i && !req_ready_o |=> req_valid_i && $stable(req_we_i) && $stable(req_addr_i)
      && $stable(req_wdata_i) && $stable(req_be_i));
  addr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_req_o |-> ({1'b0, sram_addr_o} < (AddrWidth + 1)'(NumWords)));
endmodule

// File: tb/tb_sram_stream_adapter.sv
// tb_sram_stream_adapter: directed stimulus with a queue-based response model and literal checks
module tb_sram_stream_adapter;
  logic clk_i = 0, rst_ni = 1;
  logic req_valid_i = 0, req_we_i = 0, rsp_ready_i = 0;
  logic [3:0] req_addr_i = 0, req_be_i = 0;
  logic [31:0] req_wdata_i = 0;
  logic req_ready_o, rsp_valid_o, sram_req_o, sram_we_o;
  logic [31:0] rsp_rdata_o, sram_wdata_o, sram_rdata_i;
  logic [3:0] sram_addr_o, sram_be_o;
  typedef struct {logic [31:0] d; int t;} exp_t;
  exp_t exp_q[$];
  logic [31:0] got_q[$];
  int got_t[$];
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [31:0] sram_mem [16] = '{default: 32'h0};
  int cyc = 0, checks = 0, passes = 0, acc_n = 0;
  logic init_m = 0;
  always #5 clk_i = ~clk_i;
  sram_stream_adapter #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .RspDepth(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++) if (sram_be_o[b]) sram_mem[sram_addr_o][b*8+:8] <= sram_wdata_o[b*8+:8];
      end else sram_rdata_i <= sram_mem[sram_addr_o];
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", n, act, exp);
  endtask
  initial forever begin
    logic m_rdy, m_vld;
    @(posedge clk_i);
    if (!rst_ni) begin
      exp_q.delete();
      init_m = 0;
    end else begin
      m_rdy = init_m && exp_q.size() < 3;
      m_vld = exp_q.size() > 0 && exp_q[0].t <= cyc;
      if (m_vld && rsp_ready_i) void'(exp_q.pop_front());
      if (req_valid_i && m_rdy) begin
        if (req_we_i) begin
          for (int b = 0; b < 4; b++) if (req_be_i[b]) ref_mem[req_addr_i][b*8+:8] = req_wdata_i[b*8+:8];
        end else exp_q.push_back('{d: ref_mem[req_addr_i], t: cyc + 2});
      end
      init_m = 1;
    end
    cyc++;
  end
  initial forever begin
    logic e_rdy, e_vld;
    @(negedge clk_i);
    if (!rst_ni) begin
      chk("rst_req_ready", 32'(req_ready_o), 0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
      chk("rst_sram_req", 32'(sram_req_o), 0);
    end else begin
      e_rdy = init_m && exp_q.size() < 3;
      e_vld = exp_q.size() > 0 && exp_q[0].t <= cyc;
      chk("req_ready", 32'(req_ready_o), 32'(e_rdy));
      chk("sram_req", 32'(sram_req_o), 32'(req_valid_i && e_rdy));
      if (req_valid_i && e_rdy) begin
        chk("sram_we", 32'(sram_we_o), 32'(req_we_i));
        chk("sram_addr", 32'(sram_addr_o), 32'(req_addr_i));
        chk("sram_wdata", sram_wdata_o, req_wdata_i);
        chk("sram_be", 32'(sram_be_o), 32'(req_be_i));
      end
      chk("rsp_valid", 32'(rsp_valid_o), 32'(e_vld));
      if (e_vld) chk("rsp_rdata", rsp_rdata_o, exp_q[0].d);
      if (rsp_valid_o && rsp_ready_i) begin
        got_q.push_back(rsp_rdata_o);
        got_t.push_back(cyc);
      end
      if (req_valid_i && req_ready_o) acc_n++;
    end
  end
  task automatic req(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic hold, output int ac);
    req_valid_i = 1;
    req_we_i = we;
    req_addr_i = a;
    req_wdata_i = d;
    req_be_i = be;
    ac = -1;
    for (int i = 0; i < 40 && ac < 0; i++) begin
      @(negedge clk_i);
      if (req_ready_o) ac = cyc;
      @(posedge clk_i);
      #1;
    end
    if (ac < 0) chk("req_timeout", 32'(req_ready_o), 1);
    if (!hold) req_valid_i = 0;
  endtask
  task automatic wait_rsp(output int c, output logic [31:0] d);
    c = -1;
    d = 'x;
    for (int i = 0; i < 20 && c < 0; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        c = cyc;
        d = rsp_rdata_o;
      end
      @(posedge clk_i);
      #1;
    end
    if (c < 0) chk("rsp_timeout", 32'(rsp_valid_o), 1);
  endtask
  task automatic wait_got(input int n);
    for (int i = 0; i < 40 && got_q.size() < n; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk("got_count", 32'(got_q.size()), 32'(n));
  endtask
  initial begin
    int a, c;
    int ac [8];
    logic [31:0] d;
    #1 rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    @(negedge clk_i);
    chk("t1_ready_first", 32'(req_ready_o), 0);
    chk("t1_rsp_valid", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    chk("t1_ready_second", 32'(req_ready_o), 1);
    @(posedge clk_i);
    #1 rsp_ready_i = 1;
    req(1, 3, 32'hDEADBEEF, 4'hF, 0, a);
    req(0, 3, 0, 0, 0, a);
    wait_rsp(c, d);
    chk("t2_data", d, 32'hDEADBEEF);
    chk("t2_latency", 32'(c - a), 2);
    req(1, 5, 32'hFFFFFFFF, 4'hF, 0, a);
    req(1, 5, 32'h11223344, 4'b0101, 0, a);
    req(0, 5, 0, 0, 0, a);
    wait_rsp(c, d);
    chk("t3_data", d, 32'hFF22FF44);
    chk("t3_latency", 32'(c - a), 2);
    rsp_ready_i = 0;
    for (int i = 0; i < 8; i++) req(1, 4'(i), 32'hC0DE0000 + i, 4'hF, 0, a);
    got_q.delete();
    acc_n = 0;
    for (int i = 0; i < 3; i++) req(0, 4'(i), 0, 0, 0, a);
    req_valid_i = 1;
    req_we_i = 0;
    req_addr_i = 3;
    repeat (4) begin
      @(negedge clk_i);
      chk("t4_blocked", 32'(req_ready_o), 0);
      @(posedge clk_i);
      #1;
    end
    chk("t4_accepted", 32'(acc_n), 3);
    chk("t4_no_rsp", 32'(got_q.size()), 0);
    rsp_ready_i = 1;
    req(0, 3, 0, 0, 0, a);
    req(0, 4, 0, 0, 0, a);
    wait_got(5);
    for (int i = 0; i < 5; i++) chk("t4_order", got_q[i], 32'hC0DE0000 + i);
    got_q.delete();
    got_t.delete();
    for (int i = 0; i < 8; i++) req(0, 4'(i), 0, 0, 1, ac[i]);
    req_valid_i = 0;
    wait_got(8);
    for (int i = 0; i < 8; i++) begin
      chk("t5_data", got_q[i], 32'hC0DE0000 + i);
      chk("t5_accept_gap", 32'(ac[i] - ac[0]), 32'(i));
      chk("t5_rsp_gap", 32'(got_t[i] - got_t[0]), 32'(i));
    end
    chk("t5_first_latency", 32'(got_t[0] - ac[0]), 2);
    rsp_ready_i = 0;
    req(0, 0, 0, 0, 1, a);
    req(0, 1, 0, 0, 1, a);
    req(0, 2, 0, 0, 0, a);
    chk("t6_pre_valid", 32'(rsp_valid_o), 1);
    rst_ni = 0;
    got_q.delete();
    #1;
    chk("t6_rst_valid", 32'(rsp_valid_o), 0);
    chk("t6_rst_ready", 32'(req_ready_o), 0);
    chk("t6_rst_sram_req", 32'(sram_req_o), 0);
    rsp_ready_i = 1;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("t6_no_stale", 32'(got_q.size()), 0);
    req(0, 2, 0, 0, 0, a);
    wait_rsp(c, d);
    chk("t6_mem_2", d, 32'hC0DE0002);
    req(0, 5, 0, 0, 0, a);
    wait_rsp(c, d);
    chk("t6_mem_5", d, 32'hC0DE0005);
    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
